// File: rtl/reg4_game_sequencer.sv
// ----------------------------------------------------------------------------
// reg4_game_sequencer
//   Round sequencer for the Reg4 reaction game. It turns start/abort/answer
//   events into rounds: an ARM delay with the servo timer held at home, a RUN
//   phase with the timer counting, then a WIN/LOSE result held on display.
//   After MAX_ROUNDS rounds it parks in DONE until the next start.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   start_btn      in   debounced level, acts on rising edge
//   abort_btn      in   debounced level, acts on rising edge
//   answer_valid   in   1-cycle pulse, player submitted an answer
//   answer_correct in   qualifies answer_valid
//   time_up        in   servo timer expired (level)
//   timer_run      out  1 = servo timer counts, 0 = reset/home
//   state_code     out  0 IDLE,1 ARM,2 RUN,3 WIN,4 LOSE,5 DONE
//   round_num      out  current round, 1-based, 0 in IDLE
//   score          out  correct rounds this game (saturates at 15)
//   game_over      out  high while in DONE
// ----------------------------------------------------------------------------
module reg4_game_sequencer #(
  parameter int unsigned ARM_CYCLES    = 25_000_000,
  parameter int unsigned RESULT_CYCLES = 100_000_000,
  parameter int unsigned MAX_ROUNDS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       abort_btn,
  input  logic       answer_valid,
  input  logic       answer_correct,
  input  logic       time_up,
  output logic       timer_run,
  output logic [2:0] state_code,
  output logic [3:0] round_num,
  output logic [3:0] score,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [31:0] ARM_LAST    = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] RESULT_LAST = 32'(RESULT_CYCLES - 1);
  localparam logic [3:0]  LAST_ROUND  = 4'(MAX_ROUNDS);

  state_t      r_state;
  logic        r_timer_run;
  logic [3:0]  r_round;
  logic [3:0]  r_score;
  logic        r_game_over;
  logic        r_start_q;
  logic        r_abort_q;
  logic        r_edge_en;
  logic [31:0] r_hold_cnt;

  logic w_start_rise;
  logic w_abort_rise;
  logic w_arm_done;
  logic w_result_done;
  logic w_last_round;

  // Edge detection is held off for the first clock after reset so a button
  // already held high across reset release does not count as a press.
  assign w_start_rise  = r_edge_en & start_btn & ~r_start_q;
  assign w_abort_rise  = r_edge_en & abort_btn & ~r_abort_q;
  assign w_arm_done    = (r_hold_cnt == ARM_LAST);
  assign w_result_done = (r_hold_cnt == RESULT_LAST);
  assign w_last_round  = (r_round == LAST_ROUND);

  assign state_code = r_state;
  assign timer_run  = r_timer_run;
  assign round_num  = r_round;
  assign score      = r_score;
  assign game_over  = r_game_over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer_run <= 1'b0;
      r_round     <= '0;
      r_score     <= '0;
      r_game_over <= 1'b0;
      r_start_q   <= 1'b0;
      r_abort_q   <= 1'b0;
      r_edge_en   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_edge_en <= 1'b1;
      r_start_q <= start_btn;
      r_abort_q <= abort_btn;

      if (w_abort_rise && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_timer_run <= 1'b0;
        r_round     <= '0;
        r_score     <= '0;
        r_game_over <= 1'b0;
        r_hold_cnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_rise) begin
              r_state     <= S_ARM;
              r_timer_run <= 1'b0;
              r_round     <= 4'd1;
              r_score     <= '0;
              r_hold_cnt  <= '0;
            end
          end

          S_ARM: begin
            if (w_arm_done) begin
              r_state     <= S_RUN;
              r_timer_run <= 1'b1;
              r_hold_cnt  <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 32'd1;
            end
          end

          S_RUN: begin
            // An answer in the same cycle as time_up takes precedence.
            if (answer_valid) begin
              r_timer_run <= 1'b0;
              r_hold_cnt  <= '0;
              if (answer_correct) begin
                r_state <= S_WIN;
                if (r_score != 4'hF) r_score <= r_score + 4'd1;
              end else begin
                r_state <= S_LOSE;
              end
            end else if (time_up) begin
              r_state     <= S_LOSE;
              r_timer_run <= 1'b0;
              r_hold_cnt  <= '0;
            end
          end

          S_WIN, S_LOSE: begin
            if (w_result_done) begin
              r_hold_cnt <= '0;
              if (w_last_round) begin
                r_state     <= S_DONE;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_ARM;
                r_round <= r_round + 4'd1;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + 32'd1;
            end
          end

          S_DONE: begin
            if (w_start_rise) begin
              r_state     <= S_ARM;
              r_game_over <= 1'b0;
              r_round     <= 4'd1;
              r_score     <= '0;
              r_hold_cnt  <= '0;
            end
          end

          default: begin
            r_state     <= S_IDLE;
            r_timer_run <= 1'b0;
            r_round     <= '0;
            r_score     <= '0;
            r_game_over <= 1'b0;
            r_hold_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg4_game_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reg4_game_sequencer
//   Table of per-cycle input/expected-output records for reg4_game_sequencer
//   (ARM_CYCLES=4, RESULT_CYCLES=3, MAX_ROUNDS=2), plus hand-written reset
//   sequences. Expected outputs are packed as
//   {state_code, timer_run, round_num, score, game_over}.
// ----------------------------------------------------------------------------
module tb_reg4_game_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_btn;
  logic       abort_btn;
  logic       answer_valid;
  logic       answer_correct;
  logic       time_up;
  logic       timer_run;
  logic [2:0] state_code;
  logic [3:0] round_num;
  logic [3:0] score;
  logic       game_over;

  int unsigned n_checks;
  int unsigned n_errors;

  typedef struct {
    logic        st;
    logic        ab;
    logic        av;
    logic        ac;
    logic        tu;
    int unsigned n;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];

  reg4_game_sequencer #(
    .ARM_CYCLES    (4),
    .RESULT_CYCLES (3),
    .MAX_ROUNDS    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_btn      (start_btn),
    .abort_btn      (abort_btn),
    .answer_valid   (answer_valid),
    .answer_correct (answer_correct),
    .time_up        (time_up),
    .timer_run      (timer_run),
    .state_code     (state_code),
    .round_num      (round_num),
    .score          (score),
    .game_over      (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pack(input logic [2:0] s, input logic r,
                                       input logic [3:0] rn, input logic [3:0] sc,
                                       input logic go);
    return {s, r, rn, sc, go};
  endfunction

  task automatic add(input logic st, input logic ab, input logic av, input logic ac,
                     input logic tu, input int unsigned n, input logic [2:0] s,
                     input logic r, input logic [3:0] rn, input logic [3:0] sc,
                     input logic go);
    vec_t v;
    v.st = st; v.ab = ab; v.av = av; v.ac = ac; v.tu = tu; v.n = n;
    v.exp = pack(s, r, rn, sc, go);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got st=%0d run=%0b rnd=%0d sc=%0d go=%0b, expected st=%0d run=%0b rnd=%0d sc=%0d go=%0b",
               name, got[12:10], got[9], got[8:5], got[4:1], got[0],
               exp[12:10], exp[9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [12:0] outs();
    return {state_code, timer_run, round_num, score, game_over};
  endfunction

  initial begin
    logic [12:0] e;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start_btn = 1'b0; abort_btn = 1'b0;
    answer_valid = 1'b0; answer_correct = 1'b0; time_up = 1'b0;

    //   st ab av ac tu  n   state run rnd sc go
    add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0); // start rise -> ARM
    add(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0); // RUN 4 edges after ARM entry
    add(0, 0, 0, 0, 0, 2, 2, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 1, 3, 0, 1, 1, 0); // correct -> WIN
    add(0, 0, 1, 0, 1, 2, 3, 0, 1, 1, 0); // answers/time_up ignored in WIN
    add(0, 0, 0, 0, 0, 1, 1, 0, 2, 1, 0); // round 2 ARM
    add(0, 0, 1, 1, 1, 3, 1, 0, 2, 1, 0); // ignored in ARM
    add(0, 0, 0, 0, 0, 1, 2, 1, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 4, 0, 2, 1, 0); // time_up -> LOSE
    add(0, 0, 0, 0, 0, 2, 4, 0, 2, 1, 0);
    add(0, 0, 0, 0, 0, 1, 5, 0, 2, 1, 1); // last round -> DONE
    add(0, 0, 1, 1, 1, 3, 5, 0, 2, 1, 1); // frozen in DONE
    add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0); // new game from DONE
    add(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1, 1, 3, 0, 1, 1, 0); // answer beats time_up
    add(0, 0, 0, 0, 0, 2, 3, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 0, 1, 2, 1, 2, 1, 0);
    add(1, 0, 0, 0, 0, 2, 2, 1, 2, 1, 0); // start ignored in RUN
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // abort round 2 RUN -> IDLE
    add(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0); // held start: no new rise
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 4, 0, 1, 0, 0); // wrong answer -> LOSE
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // abort in LOSE
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    #1;
    check("reset_state", outs(), pack(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      for (int unsigned k = 0; k < vecs[i].n; k++) begin
        @(negedge clk);
        start_btn      = vecs[i].st;
        abort_btn      = vecs[i].ab;
        answer_valid   = vecs[i].av;
        answer_correct = vecs[i].ac;
        time_up        = vecs[i].tu;
        sb.push_back(vecs[i].exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d_c%0d", i, k), outs(), e);
      end
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start_btn = 1'b0; abort_btn = 1'b0; answer_valid = 1'b0; time_up = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    begin
      int unsigned budget;
      budget = 0;
      @(posedge clk); #1;
      while (state_code != 3'd2 && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      check("reach_run", outs(), pack(2, 1, 1, 0, 0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_run", outs(), pack(0, 0, 0, 0, 0));

    // start_btn stays high across reset release: must not start a game.
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("held_start_c%0d", k), outs(), pack(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    start_btn = 1'b0;
    @(posedge clk); #1;
    check("start_low", outs(), pack(0, 0, 0, 0, 0));
    @(negedge clk);
    start_btn = 1'b1;
    @(posedge clk); #1;
    check("start_after_release", outs(), pack(1, 0, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
